// File: rtl/hazard_pkg.sv
// Shared encodings, scoreboard payload types and helpers for the hazard controller.
package hazard_pkg;

  localparam int unsigned REG_W    = 5;
  localparam int unsigned TNEW_W   = 2;
  localparam int unsigned TUSE_W   = 2;
  localparam int unsigned WSEL_W   = 2;
  localparam int unsigned FWDSEL_W = 4;

  // Write-source encodings
  localparam logic [WSEL_W-1:0] WSEL_ALU = 2'b00;
  localparam logic [WSEL_W-1:0] WSEL_MEM = 2'b01;
  localparam logic [WSEL_W-1:0] WSEL_PC8 = 2'b10;

  // Forward-mux select encodings
  localparam logic [FWDSEL_W-1:0] FWD_ORIG = 4'b0000;
  localparam logic [FWDSEL_W-1:0] FWD_W    = 4'b0001;
  localparam logic [FWDSEL_W-1:0] FWD_M    = 4'b0010;
  localparam logic [FWDSEL_W-1:0] FWD_PC8M = 4'b0011;
  localparam logic [FWDSEL_W-1:0] FWD_PC8E = 4'b0100;

  // Operand use / result-ready timing
  localparam logic [TUSE_W-1:0] TUSE_NONE = 2'd3;
  localparam logic [TNEW_W-1:0] TNEW_ALU  = 2'd1;
  localparam logic [TNEW_W-1:0] TNEW_LOAD = 2'd2;
  localparam logic [TNEW_W-1:0] TNEW_LINK = 2'd0;

  // In-flight writer held in the E slot
  typedef struct packed {
    logic [REG_W-1:0]  rs;
    logic [REG_W-1:0]  rt;
    logic [REG_W-1:0]  dst;
    logic [TNEW_W-1:0] tnew;
    logic [WSEL_W-1:0] wsel;
  } e_entry_t;

  // In-flight writer held in the M slot (rt kept for store-data forwarding)
  typedef struct packed {
    logic [REG_W-1:0]  rt;
    logic [REG_W-1:0]  dst;
    logic [TNEW_W-1:0] tnew;
    logic [WSEL_W-1:0] wsel;
  } m_entry_t;

  // A slot matches a source only when it writes a non-zero register
  function automatic logic reg_match(input logic [REG_W-1:0] dst,
                                     input logic [REG_W-1:0] src);
    return (dst != '0) && (dst == src);
  endfunction

  // Result-ready countdown, saturating at zero
  function automatic logic [TNEW_W-1:0] tnew_age(input logic [TNEW_W-1:0] tnew);
    return (tnew == '0) ? '0 : tnew - TNEW_W'(1);
  endfunction

endpackage

// File: rtl/hazard_operand.sv
// One source operand: stall request plus its D-stage and E-stage forward selects.
module hazard_operand
  import hazard_pkg::*;
(
  input  logic [REG_W-1:0]    src_d_i,
  input  logic [TUSE_W-1:0]   tuse_d_i,
  input  logic [REG_W-1:0]    src_e_i,
  input  logic [REG_W-1:0]    dst_e_i,
  input  logic [TNEW_W-1:0]   tnew_e_i,
  input  logic [WSEL_W-1:0]   wsel_e_i,
  input  logic [REG_W-1:0]    dst_m_i,
  input  logic [TNEW_W-1:0]   tnew_m_i,
  input  logic [WSEL_W-1:0]   wsel_m_i,
  input  logic [REG_W-1:0]    dst_w_i,
  output logic                stall_c_o,
  output logic [FWDSEL_W-1:0] fwd_d_c_o,
  output logic [FWDSEL_W-1:0] fwd_e_c_o
);

  logic hit_e_d;
  logic hit_m_d;
  logic hit_w_d;
  logic hit_m_e;
  logic hit_w_e;

  // Slot matches for the D-stage and E-stage copies of this operand
  always_comb begin
    hit_e_d = reg_match(dst_e_i, src_d_i);
    hit_m_d = reg_match(dst_m_i, src_d_i);
    hit_w_d = reg_match(dst_w_i, src_d_i);
    hit_m_e = reg_match(dst_m_i, src_e_i);
    hit_w_e = reg_match(dst_w_i, src_e_i);
  end

  // Stall when a matching E/M writer will not be ready by the time the operand is used
  always_comb begin
    stall_c_o = 1'b0;
    if (tuse_d_i != TUSE_NONE) begin
      stall_c_o = (hit_e_d && (tnew_e_i > tuse_d_i)) ||
                  (hit_m_d && (tnew_m_i > tuse_d_i));
    end
  end

  // D-stage select: youngest matching writer decides, E > M > W
  always_comb begin
    fwd_d_c_o = FWD_ORIG;
    if (hit_e_d) begin
      if (wsel_e_i == WSEL_PC8) fwd_d_c_o = FWD_PC8E;
    end else if (hit_m_d) begin
      if (wsel_m_i == WSEL_PC8)  fwd_d_c_o = FWD_PC8M;
      else if (tnew_m_i == '0)   fwd_d_c_o = FWD_M;
    end else if (hit_w_d) begin
      fwd_d_c_o = FWD_W;
    end
  end

  // E-stage select: same rules, M > W only
  always_comb begin
    fwd_e_c_o = FWD_ORIG;
    if (hit_m_e) begin
      if (wsel_m_i == WSEL_PC8)  fwd_e_c_o = FWD_PC8M;
      else if (tnew_m_i == '0)   fwd_e_c_o = FWD_M;
    end else if (hit_w_e) begin
      fwd_e_c_o = FWD_W;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard/forwarding controller: E/M/W writer scoreboard, per-operand hazard logic,
// and a saturating stall-cycle counter.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [REG_W-1:0]    rs_D,
  input  logic [REG_W-1:0]    rt_D,
  input  logic [TUSE_W-1:0]   tuse_rs_D,
  input  logic [TUSE_W-1:0]   tuse_rt_D,
  input  logic [REG_W-1:0]    dst_D,
  input  logic [TNEW_W-1:0]   tnew_D,
  input  logic [WSEL_W-1:0]   wsel_D,
  output logic                stall,
  output logic                flush_E,
  output logic [FWDSEL_W-1:0] fwd_rs_D,
  output logic [FWDSEL_W-1:0] fwd_rt_D,
  output logic [FWDSEL_W-1:0] fwd_rs_E,
  output logic [FWDSEL_W-1:0] fwd_rt_E,
  output logic                fwd_rt_M,
  output logic [CNT_W-1:0]    stall_cycles
);

  e_entry_t         e_q, e_d;
  m_entry_t         m_q, m_d;
  logic [REG_W-1:0] w_dst_q, w_dst_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             stall_rs;
  logic             stall_rt;

  hazard_operand u_rs (
    .src_d_i   (rs_D),
    .tuse_d_i  (tuse_rs_D),
    .src_e_i   (e_q.rs),
    .dst_e_i   (e_q.dst),
    .tnew_e_i  (e_q.tnew),
    .wsel_e_i  (e_q.wsel),
    .dst_m_i   (m_q.dst),
    .tnew_m_i  (m_q.tnew),
    .wsel_m_i  (m_q.wsel),
    .dst_w_i   (w_dst_q),
    .stall_c_o (stall_rs),
    .fwd_d_c_o (fwd_rs_D),
    .fwd_e_c_o (fwd_rs_E)
  );

  hazard_operand u_rt (
    .src_d_i   (rt_D),
    .tuse_d_i  (tuse_rt_D),
    .src_e_i   (e_q.rt),
    .dst_e_i   (e_q.dst),
    .tnew_e_i  (e_q.tnew),
    .wsel_e_i  (e_q.wsel),
    .dst_m_i   (m_q.dst),
    .tnew_m_i  (m_q.tnew),
    .wsel_m_i  (m_q.wsel),
    .dst_w_i   (w_dst_q),
    .stall_c_o (stall_rt),
    .fwd_d_c_o (fwd_rt_D),
    .fwd_e_c_o (fwd_rt_E)
  );

  // Combined stall, bubble request and M-stage store-data select
  always_comb begin
    stall        = stall_rs | stall_rt;
    flush_E      = stall_rs | stall_rt;
    fwd_rt_M     = reg_match(w_dst_q, m_q.rt);
    stall_cycles = cnt_q;
  end

  // Scoreboard advance: D->E (bubble on stall), E->M with aged tnew, M->W
  always_comb begin
    e_d = '0;
    if (!stall) begin
      e_d.rs   = rs_D;
      e_d.rt   = rt_D;
      e_d.dst  = dst_D;
      e_d.tnew = tnew_D;
      e_d.wsel = wsel_D;
    end
    m_d.rt   = e_q.rt;
    m_d.dst  = e_q.dst;
    m_d.tnew = tnew_age(e_q.tnew);
    m_d.wsel = e_q.wsel;
    w_dst_d  = m_q.dst;
  end

  // Stall-cycle counter, holds at all-ones
  always_comb begin
    cnt_d = cnt_q;
    if (stall && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + CNT_W'(1);
  end

  // Scoreboard and counter registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      e_q     <= '0;
      m_q     <= '0;
      w_dst_q <= '0;
      cnt_q   <= '0;
    end else begin
      e_q     <= e_d;
      m_q     <= m_d;
      w_dst_q <= w_dst_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: inputs change on negedge, outputs sampled 1 ns later.
module tb_hazard_ctrl;

  localparam int unsigned CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic [4:0]       rs_D, rt_D, dst_D;
  logic [1:0]       tuse_rs_D, tuse_rt_D, tnew_D, wsel_D;
  logic             stall, flush_E, fwd_rt_M;
  logic [3:0]       fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E;
  logic [CNT_W-1:0] stall_cycles;

  int n_vec = 0;
  int n_err = 0;

  hazard_ctrl #(.CNT_W(CNT_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .rs_D         (rs_D),
    .rt_D         (rt_D),
    .tuse_rs_D    (tuse_rs_D),
    .tuse_rt_D    (tuse_rt_D),
    .dst_D        (dst_D),
    .tnew_D       (tnew_D),
    .wsel_D       (wsel_D),
    .stall        (stall),
    .flush_E      (flush_E),
    .fwd_rs_D     (fwd_rs_D),
    .fwd_rt_D     (fwd_rt_D),
    .fwd_rs_E     (fwd_rs_E),
    .fwd_rt_E     (fwd_rt_E),
    .fwd_rt_M     (fwd_rt_M),
    .stall_cycles (stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic [4:0] rs, input logic [4:0] rt,
                       input logic [1:0] trs, input logic [1:0] trt,
                       input logic [4:0] dst, input logic [1:0] tnew,
                       input logic [1:0] wsel);
    rs_D = rs; rt_D = rt; tuse_rs_D = trs; tuse_rt_D = trt;
    dst_D = dst; tnew_D = tnew; wsel_D = wsel;
  endtask

  task automatic drive_nop();
    drive(5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd0, 2'd0);
  endtask

  task automatic next_cyc();
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    drive_nop();
    #2 reset = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    drive(5'($urandom), 5'($urandom), 2'($urandom), 2'($urandom),
          5'($urandom_range(31, 1)), 2'd2, 2'd1);
    next_cyc();
    drive(5'($urandom), 5'($urandom), 2'd0, 2'd0, 5'($urandom), 2'd1, 2'd2);
    next_cyc();
    #1;
    n_vec++;
    if (stall !== 1'b0 || flush_E !== 1'b0) begin
      n_err++; $display("FAIL reset_stall: got stall=%b flush=%b want 0/0", stall, flush_E);
    end
    n_vec++;
    if ({fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E} !== 16'h0 || fwd_rt_M !== 1'b0) begin
      n_err++; $display("FAIL reset_fwd: got %h %h %h %h m=%b want all 0",
                        fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E, fwd_rt_M);
    end
    n_vec++;
    if (stall_cycles !== 4'd0) begin
      n_err++; $display("FAIL reset_cnt: got %0d want 0", stall_cycles);
    end
    reset = 1'b0;
  endtask

  // add $1 then beq $1 (tuse 0)
  task automatic test_alu_use();
    do_reset();
    drive(5'd2, 5'd3, 2'd1, 2'd1, 5'd1, 2'd1, 2'd0);
    next_cyc();
    drive(5'd1, 5'd0, 2'd0, 2'd3, 5'd0, 2'd0, 2'd0);
    #1;
    n_vec++;
    if (stall !== 1'b1 || flush_E !== 1'b1) begin
      n_err++; $display("FAIL alu_use_stall: got stall=%b flush=%b want 1/1", stall, flush_E);
    end
    next_cyc();
    #1;
    n_vec++;
    if (stall !== 1'b0 || fwd_rs_D !== 4'b0010) begin
      n_err++; $display("FAIL alu_use_fwd: got stall=%b fwd_rs_D=%b want 0/0010", stall, fwd_rs_D);
    end
  endtask

  // lw $2 then add $3,$2 (tuse 1)
  task automatic test_load_use();
    do_reset();
    drive(5'd0, 5'd0, 2'd3, 2'd3, 5'd2, 2'd2, 2'd1);
    next_cyc();
    drive(5'd2, 5'd0, 2'd1, 2'd3, 5'd3, 2'd1, 2'd0);
    #1;
    n_vec++;
    if (stall !== 1'b1) begin
      n_err++; $display("FAIL load_use_stall: got %b want 1", stall);
    end
    next_cyc();
    #1;
    n_vec++;
    if (stall !== 1'b0 || fwd_rs_D !== 4'b0000) begin
      n_err++; $display("FAIL load_use_release: got stall=%b fwd_rs_D=%b want 0/0000", stall, fwd_rs_D);
    end
    next_cyc();
    drive_nop();
    #1;
    n_vec++;
    if (fwd_rs_E !== 4'b0001) begin
      n_err++; $display("FAIL load_use_fwd_e: got %b want 0001", fwd_rs_E);
    end
  endtask

  // jal then jr $31
  task automatic test_link();
    do_reset();
    drive(5'd0, 5'd0, 2'd3, 2'd3, 5'd31, 2'd0, 2'd2);
    next_cyc();
    drive(5'd31, 5'd0, 2'd0, 2'd3, 5'd0, 2'd0, 2'd0);
    #1;
    n_vec++;
    if (stall !== 1'b0 || fwd_rs_D !== 4'b0100) begin
      n_err++; $display("FAIL link_e: got stall=%b fwd_rs_D=%b want 0/0100", stall, fwd_rs_D);
    end
    next_cyc();
    #1;
    n_vec++;
    if (fwd_rs_D !== 4'b0011 || fwd_rs_E !== 4'b0011) begin
      n_err++; $display("FAIL link_m: got fwd_rs_D=%b fwd_rs_E=%b want 0011/0011", fwd_rs_D, fwd_rs_E);
    end
  endtask

  // Writer to $0 then reader of $0
  task automatic test_zero_reg();
    do_reset();
    drive(5'd0, 5'd0, 2'd1, 2'd1, 5'd0, 2'd2, 2'd1);
    next_cyc();
    drive(5'd0, 5'd0, 2'd0, 2'd0, 5'd0, 2'd0, 2'd0);
    #1;
    n_vec++;
    if (stall !== 1'b0 || fwd_rs_D !== 4'b0000 || fwd_rt_D !== 4'b0000) begin
      n_err++; $display("FAIL zero_d: got stall=%b rs=%b rt=%b want 0/0000/0000", stall, fwd_rs_D, fwd_rt_D);
    end
    next_cyc();
    #1;
    n_vec++;
    if ({fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E} !== 16'h0 || fwd_rt_M !== 1'b0 || stall !== 1'b0) begin
      n_err++; $display("FAIL zero_e: got %h %h %h %h m=%b stall=%b want all 0",
                        fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E, fwd_rt_M, stall);
    end
  endtask

  // lw $5 then sw with rt=$5 (tuse 2): data reaches the store in M from W
  task automatic test_store_data();
    do_reset();
    drive(5'd0, 5'd0, 2'd3, 2'd3, 5'd5, 2'd2, 2'd1);
    next_cyc();
    drive(5'd6, 5'd5, 2'd1, 2'd2, 5'd0, 2'd0, 2'd0);
    #1;
    n_vec++;
    if (stall !== 1'b0 || fwd_rt_D !== 4'b0000) begin
      n_err++; $display("FAIL store_d: got stall=%b fwd_rt_D=%b want 0/0000", stall, fwd_rt_D);
    end
    next_cyc();
    drive_nop();
    #1;
    n_vec++;
    if (fwd_rt_E !== 4'b0000) begin
      n_err++; $display("FAIL store_e: got %b want 0000", fwd_rt_E);
    end
    next_cyc();
    #1;
    n_vec++;
    if (fwd_rt_M !== 1'b1) begin
      n_err++; $display("FAIL store_m: got %b want 1", fwd_rt_M);
    end
  endtask

  // Two back-to-back writers of $4: the younger one wins
  task automatic test_back_to_back();
    do_reset();
    drive(5'd0, 5'd0, 2'd3, 2'd3, 5'd4, 2'd1, 2'd0);
    next_cyc();
    drive(5'd0, 5'd0, 2'd3, 2'd3, 5'd4, 2'd1, 2'd0);
    next_cyc();
    drive(5'd4, 5'd0, 2'd1, 2'd3, 5'd0, 2'd0, 2'd0);
    #1;
    n_vec++;
    if (stall !== 1'b0 || fwd_rs_D !== 4'b0000) begin
      n_err++; $display("FAIL b2b_d: got stall=%b fwd_rs_D=%b want 0/0000", stall, fwd_rs_D);
    end
    next_cyc();
    drive(5'd4, 5'd0, 2'd0, 2'd3, 5'd0, 2'd0, 2'd0);
    #1;
    n_vec++;
    if (fwd_rs_E !== 4'b0010 || fwd_rs_D !== 4'b0010 || stall !== 1'b0) begin
      n_err++; $display("FAIL b2b_e: got fwd_rs_E=%b fwd_rs_D=%b stall=%b want 0010/0010/0",
                        fwd_rs_E, fwd_rs_D, stall);
    end
  endtask

  // Repeated load-use (tuse 0) gives two stall cycles per round; counter saturates
  task automatic test_stall_counter();
    int exp_cnt;
    do_reset();
    for (int k = 0; k < 10; k++) begin
      drive(5'd0, 5'd0, 2'd3, 2'd3, 5'd2, 2'd2, 2'd1);
      next_cyc();
      drive(5'd2, 5'd0, 2'd0, 2'd3, 5'd0, 2'd0, 2'd0);
      #1;
      n_vec++;
      if (stall !== 1'b1) begin
        n_err++; $display("FAIL cnt_stall_e round %0d: got %b want 1", k, stall);
      end
      next_cyc();
      #1;
      n_vec++;
      if (stall !== 1'b1) begin
        n_err++; $display("FAIL cnt_stall_m round %0d: got %b want 1", k, stall);
      end
      next_cyc();
      #1;
      exp_cnt = (2 * (k + 1) > 15) ? 15 : 2 * (k + 1);
      n_vec++;
      if (stall !== 1'b0 || fwd_rs_D !== 4'b0001 || stall_cycles !== 4'(exp_cnt)) begin
        n_err++; $display("FAIL cnt_round %0d: got stall=%b fwd=%b cnt=%0d want 0/0001/%0d",
                          k, stall, fwd_rs_D, stall_cycles, exp_cnt);
      end
    end
    drive(5'd0, 5'd0, 2'd3, 2'd3, 5'd2, 2'd2, 2'd1);
    next_cyc();
    drive(5'd2, 5'd0, 2'd0, 2'd3, 5'd0, 2'd0, 2'd0);
    #1;
    n_vec++;
    if (stall !== 1'b1 || stall_cycles !== 4'd15) begin
      n_err++; $display("FAIL cnt_pre_reset: got stall=%b cnt=%0d want 1/15", stall, stall_cycles);
    end
    reset = 1'b1;
    #1;
    n_vec++;
    if (stall !== 1'b0 || flush_E !== 1'b0 || stall_cycles !== 4'd0) begin
      n_err++; $display("FAIL mid_stall_reset: got stall=%b flush=%b cnt=%0d want 0/0/0",
                        stall, flush_E, stall_cycles);
    end
    #1 reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    drive_nop();
    test_reset();
    test_alu_use();
    test_load_use();
    test_link();
    test_zero_reg();
    test_store_data();
    test_back_to_back();
    test_stall_counter();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
